// File: rtl/game_pkg.sv
// Shared game-state definitions for the score keeper and its BCD adder.
package game_pkg;

    localparam int BCD_W   = 4;
    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_OVER     = 2'd3
    } game_state_t;

    // Binary 0..99 to two packed BCD digits (tens in [7:4]).
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// Combinational BCD adder: DIGITS-digit score plus a 2-digit BCD addend,
// clamping to all nines when the top digit would carry out.
module bcd_sat_adder
    import game_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_W*DIGITS-1:0] score,
    input  logic [7:0]              addend,
    output logic [BCD_W*DIGITS-1:0] sum
);

    logic [DIGITS:0]         carry;
    logic [BCD_W*DIGITS-1:0] raw;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] b;
            logic [4:0] s;
            // Only the two low digits receive addend; upper digits just ripple the carry.
            if (gi < 2) begin : g_add
                assign b = addend[BCD_W*gi +: BCD_W];
            end else begin : g_zero
                assign b = 4'd0;
            end
            assign s                     = {1'b0, score[BCD_W*gi +: BCD_W]} + {1'b0, b} + {4'd0, carry[gi]};
            assign carry[gi+1]           = (s > 5'd9);
            assign raw[BCD_W*gi +: BCD_W] = carry[gi+1] ? 4'(s + 5'd6) : s[3:0];
        end
    endgenerate

    assign sum = carry[DIGITS] ? {DIGITS{4'h9}} : raw;

endmodule

// File: rtl/score_keeper.sv
// Game-state tracker: edge-detected score/hit channels, saturating BCD score,
// lives with post-hit cooldown, level counter and the IDLE/PLAY/COOLDOWN/OVER FSM.
module score_keeper
    import game_pkg::*;
#(
    parameter int                      N_SCORE        = 2,
    parameter logic [4*N_SCORE-1:0]    PTS            = 8'h51,
    parameter int                      DIGITS         = 4,
    parameter int                      LIVES          = 3,
    parameter int                      COOLDOWN_TICKS = 32,
    parameter int                      MAX_LEVEL      = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_en,
    input  logic                      start,
    input  logic [N_SCORE-1:0]        evt_score,
    input  logic                      evt_hit,
    output logic [BCD_W*DIGITS-1:0]   score_bcd,
    output logic [LIVES_W-1:0]        lives,
    output logic [LEVEL_W-1:0]        level,
    output logic [1:0]                state,
    output logic                      hit_flash,
    output logic                      game_over
);

    localparam int CNT_W   = $clog2(COOLDOWN_TICKS + 1);
    localparam int LVL_IDX = (DIGITS == 2) ? 1 : 2;

    game_state_t               state_reg;
    logic [BCD_W*DIGITS-1:0]   score_reg;
    logic [LIVES_W-1:0]        lives_reg;
    logic [LEVEL_W-1:0]        level_reg;
    logic                      hit_flash_reg;
    logic                      game_over_reg;
    logic [N_SCORE-1:0]        prev_score_reg;
    logic                      prev_hit_reg;
    logic [CNT_W-1:0]          cool_cnt_reg;

    logic [N_SCORE-1:0]        rise;
    logic                      hit_rise;
    logic [6:0]                part [N_SCORE+1];
    logic [7:0]                addend_bcd;
    logic [BCD_W*DIGITS-1:0]   score_sum;
    logic                      level_step;
    logic [LEVEL_W-1:0]        level_next;

    assign rise     = evt_score & ~prev_score_reg;
    assign hit_rise = evt_hit & ~prev_hit_reg;

    // Running binary sum of the weights of every channel that rose this tick.
    assign part[0] = 7'd0;
    genvar gi;
    generate
        for (gi = 0; gi < N_SCORE; gi++) begin : g_pts
            assign part[gi+1] = part[gi] + (rise[gi] ? {3'd0, PTS[4*gi +: 4]} : 7'd0);
        end
    endgenerate

    assign addend_bcd = bin_to_bcd2(part[N_SCORE]);

    bcd_sat_adder #(
        .DIGITS (DIGITS)
    ) u_adder (
        .score  (score_reg),
        .addend (addend_bcd),
        .sum    (score_sum)
    );

    // A level is earned whenever the add changes the hundreds digit; nothing moves once saturated.
    assign level_step = (score_sum[BCD_W*LVL_IDX +: BCD_W] != score_reg[BCD_W*LVL_IDX +: BCD_W])
                        && (score_reg != {DIGITS{4'h9}});
    assign level_next = (level_step && (level_reg != LEVEL_W'(MAX_LEVEL))) ? level_reg + 1'b1 : level_reg;

    // Game FSM plus all registered game state; only tick cycles advance anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            score_reg      <= '0;
            lives_reg      <= LIVES_W'(LIVES);
            level_reg      <= '0;
            hit_flash_reg  <= 1'b0;
            game_over_reg  <= 1'b0;
            prev_score_reg <= '1;
            prev_hit_reg   <= 1'b1;
            cool_cnt_reg   <= '0;
        end else if (tick_en) begin
            prev_score_reg <= evt_score;
            prev_hit_reg   <= evt_hit;
            case (state_reg)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_reg     <= ST_PLAY;
                        score_reg     <= '0;
                        lives_reg     <= LIVES_W'(LIVES);
                        level_reg     <= '0;
                        hit_flash_reg <= 1'b0;
                        game_over_reg <= 1'b0;
                        cool_cnt_reg  <= '0;
                    end
                end
                ST_PLAY: begin
                    score_reg <= score_sum;
                    level_reg <= level_next;
                    if (hit_rise) begin
                        lives_reg <= lives_reg - 1'b1;
                        if (lives_reg == LIVES_W'(1)) begin
                            state_reg     <= ST_OVER;
                            game_over_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_COOLDOWN;
                            hit_flash_reg <= 1'b1;
                            cool_cnt_reg  <= CNT_W'(COOLDOWN_TICKS);
                        end
                    end
                end
                ST_COOLDOWN: begin
                    score_reg    <= score_sum;
                    level_reg    <= level_next;
                    cool_cnt_reg <= cool_cnt_reg - 1'b1;
                    if (cool_cnt_reg == CNT_W'(1)) begin
                        state_reg     <= ST_PLAY;
                        hit_flash_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign score_bcd = score_reg;
    assign lives     = lives_reg;
    assign level     = level_reg;
    assign state     = state_reg;
    assign hit_flash = hit_flash_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with default parameters (ch0 = 1 pt, ch1 = 5 pts).
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic        start;
    logic [1:0]  evt_score;
    logic        evt_hit;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic [1:0]  state;
    logic        hit_flash;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
        .start     (start),
        .evt_score (evt_score),
        .evt_hit   (evt_hit),
        .score_bcd (score_bcd),
        .lives     (lives),
        .level     (level),
        .state     (state),
        .hit_flash (hit_flash),
        .game_over (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick: inputs applied at a falling edge, outputs sampled at the next falling edge.
    task automatic tick(input logic [1:0] es, input logic eh, input logic st);
        evt_score = es;
        evt_hit   = eh;
        start     = st;
        tick_en   = 1'b1;
        @(negedge clk);
        tick_en   = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b0; start = 1'b0; evt_score = 2'b00; evt_hit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_state", state, 0);
        check("rst_score", score_bcd, 16'h0000);
        check("rst_lives", lives, 3);
        check("rst_level", level, 0);
        check("rst_flash", hit_flash, 0);
        check("rst_over",  game_over, 0);

        // 1: start
        tick(2'b00, 1'b0, 1'b1);
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_score", score_bcd, 16'h0000);
        $display("step start: state=%0d lives=%0d score=%h", state, lives, score_bcd);

        // Non-tick cycles change nothing.
        evt_score = 2'b01;
        repeat (3) @(negedge clk);
        check("notick_score", score_bcd, 16'h0000);

        // 2: held level counts once; both channels together add 6
        for (int i = 0; i < 10; i++) tick(2'b01, 1'b0, 1'b0);
        check("held_ch0", score_bcd, 16'h0001);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b11, 1'b0, 1'b0);
        check("both_ch", score_bcd, 16'h0007);
        tick(2'b00, 1'b0, 1'b1);
        check("start_in_play_state", state, 1);
        check("start_in_play_score", score_bcd, 16'h0007);
        $display("step events: score=%h", score_bcd);

        // 4: hit in PLAY, then hits ignored during cooldown while ch0 edges still count
        tick(2'b00, 1'b1, 1'b0);
        check("hit_lives", lives, 2);
        check("hit_state", state, 2);
        check("hit_flash", hit_flash, 1);
        for (int i = 0; i < 31; i++) tick({1'b0, i[0]}, i[0], 1'b0);
        check("cool_state", state, 2);
        check("cool_flash", hit_flash, 1);
        check("cool_lives", lives, 2);
        check("cool_score", score_bcd, 16'h0022);
        tick(2'b00, 1'b0, 1'b0);
        check("cool_end_state", state, 1);
        check("cool_end_flash", hit_flash, 0);
        $display("step cooldown: lives=%0d score=%h", lives, score_bcd);

        // 5: down to one life, then score edge plus fatal hit on the same tick
        tick(2'b00, 1'b1, 1'b0);
        check("lives1", lives, 1);
        for (int i = 0; i < 31; i++) tick(2'b00, 1'b0, 1'b0);
        check("cool2_state", state, 2);
        tick(2'b00, 1'b0, 1'b0);
        check("cool2_end", state, 1);
        tick(2'b01, 1'b1, 1'b0);
        check("fatal_score", score_bcd, 16'h0023);
        check("fatal_lives", lives, 0);
        check("fatal_state", state, 3);
        check("fatal_over",  game_over, 1);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b01, 1'b1, 1'b0);
        check("over_frozen_score", score_bcd, 16'h0023);
        check("over_frozen_lives", lives, 0);
        tick(2'b00, 1'b0, 1'b1);
        check("restart_state", state, 1);
        check("restart_score", score_bcd, 16'h0000);
        check("restart_lives", lives, 3);
        check("restart_over",  game_over, 0);
        $display("step game over/restart: state=%0d score=%h", state, score_bcd);

        // 3: 165 x (+6) + 5 = 995, nine hundreds crossings
        for (int i = 0; i < 165; i++) begin
            tick(2'b11, 1'b0, 1'b0);
            tick(2'b00, 1'b0, 1'b0);
        end
        tick(2'b10, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        check("pre_score", score_bcd, 16'h0995);
        check("pre_level", level, 9);
        tick(2'b10, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        check("k_score", score_bcd, 16'h1000);
        check("k_level", level, 10);
        for (int i = 0; i < 1499; i++) begin
            tick(2'b11, 1'b0, 1'b0);
            tick(2'b00, 1'b0, 1'b0);
        end
        check("near_score", score_bcd, 16'h9994);
        check("near_level", level, 15);
        tick(2'b11, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        check("sat_score", score_bcd, 16'h9999);
        tick(2'b01, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        check("sat_hold_score", score_bcd, 16'h9999);
        check("sat_hold_level", level, 15);
        $display("step saturate: score=%h level=%0d", score_bcd, level);

        // 6: reset mid-cooldown with hit held high; held hit after restart is not an edge
        tick(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(2'b00, 1'b1, 1'b0);
        check("pre_rst_state", state, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_score", score_bcd, 16'h0000);
        check("mid_rst_lives", lives, 3);
        check("mid_rst_level", level, 0);
        check("mid_rst_flash", hit_flash, 0);
        tick(2'b00, 1'b1, 1'b1);
        check("rst_start_state", state, 1);
        tick(2'b00, 1'b1, 1'b0);
        check("held_hit_lives", lives, 3);
        check("held_hit_state", state, 1);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        check("new_hit_lives", lives, 2);
        $display("step reset: state=%0d lives=%0d", state, lives);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
